ah_packet_packer: RTL and testbench

Parametrised narrow-to-wide packet packer with credit flow control on both sides. It collates up to RATIO narrow words into one wide word and supports early flush on an end-of-packet marker, with a lane-valid mask. It buffers input in a small FIFO, and sits between a narrow streaming producer and a wide consumer in the AH packet-conversion path. Successor to the fixed-width packet converters: generic widths and ratio, lane ordering, partial packets and error flags.

---
 rtl/ah_pkt_pkg.sv | 15 +
 rtl/ah_packet_packer_if.sv | 28 ++
 rtl/ah_sync_fifo.sv | 46 ++++
 rtl/ah_packet_packer.sv | 149 ++++++++++++++
 tb/tb_ah_packet_packer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ah_pkt_pkg.sv
// Shared types and helpers for the AH narrow-to-wide packet packer.
package ah_pkt_pkg;

    // Packer control state: gather narrow words, or wait for an output credit.
    typedef enum logic [0:0] {
        StCollect,
        StHold
    } pk_state_e;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ah_packet_packer_if.sv
// Narrow producer side and wide consumer side of the packet packer.
interface ah_packet_packer_if #(
    parameter int unsigned WIN   = 8,
    parameter int unsigned RATIO = 4
);
    logic [WIN-1:0]       wdata;
    logic                 wlast;
    logic                 wvalid;
    logic                 wcredit;
    logic [WIN*RATIO-1:0] rdata;
    logic [RATIO-1:0]     rkeep;
    logic                 rvalid;
    logic                 rcredit;
    logic                 err_ovf;
    logic                 err_cred;

    // Environment view: drives narrow words and returns output credits.
    modport master (
        output wdata, wlast, wvalid, rcredit,
        input  wcredit, rdata, rkeep, rvalid, err_ovf, err_cred
    );

    // Packer view.
    modport slave (
        input  wdata, wlast, wvalid, rcredit,
        output wcredit, rdata, rkeep, rvalid, err_ovf, err_cred
    );
endinterface

// File: rtl/ah_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push on full and pop on empty are ignored.
module ah_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [AddrW:0]   wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Full when the index bits match but the wrap bits differ.
    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                  (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        data_o  = mem_q[rptr_q[AddrW-1:0]];
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
    end
endmodule

// File: rtl/ah_packet_packer.sv
// Collates up to RATIO narrow words into one wide word with credit flow control both sides.
module ah_packet_packer
    import ah_pkt_pkg::*;
#(
    parameter int unsigned WIN       = 8,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RCRED_MAX = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rstn,
    ah_packet_packer_if.slave bus
);
    localparam int unsigned LaneW  = cnt_width(RATIO - 1);
    localparam int unsigned OcredW = cnt_width(RCRED_MAX);
    // Headroom for pops from words pushed without a credit.
    localparam int unsigned IcredW = cnt_width(2 * DEPTH);

    pk_state_e                   state_q;
    logic [LaneW-1:0]            lane_q;
    logic [RATIO-1:0][WIN-1:0]   coll_q, coll_d;
    logic [RATIO-1:0]            ckeep_q, ckeep_d;
    logic [OcredW-1:0]           ocred_q, ocred_d;
    logic [IcredW-1:0]           icred_q, icred_d;
    logic                        wcredit_q, rvalid_q, err_ovf_q, err_cred_q;
    logic [WIN*RATIO-1:0]        rdata_q, pdata;
    logic [RATIO-1:0]            rkeep_q, pkeep;

    logic           fifo_full, fifo_empty, pop, complete, fire, cred_err;
    logic [WIN:0]   fifo_rd;

    ah_sync_fifo #(
        .WIDTH (WIN + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (bus.wvalid),
        .data_i  ({bus.wlast, bus.wdata}),
        .pop_i   (pop),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pop/complete/fire decisions, collation preview, lane ordering and credit arithmetic.
    always_comb begin
        pop     = (state_q == StCollect) && !fifo_empty;
        coll_d  = coll_q;
        ckeep_d = ckeep_q;
        if (pop) begin
            coll_d[lane_q]  = fifo_rd[WIN-1:0];
            ckeep_d[lane_q] = 1'b1;
        end
        complete = pop && ((lane_q == LaneW'(RATIO - 1)) || fifo_rd[WIN]);
        // Only credit held at the start of the cycle may be spent.
        fire = (ocred_q != '0) && (complete || (state_q == StHold));

        pdata = '0;
        pkeep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (LSB_FIRST) begin
                pdata[i*WIN +: WIN] = coll_d[i];
                pkeep[i]            = ckeep_d[i];
            end else begin
                pdata[(RATIO-1-i)*WIN +: WIN] = coll_d[i];
                pkeep[RATIO-1-i]              = ckeep_d[i];
            end
        end

        ocred_d  = ocred_q;
        cred_err = 1'b0;
        unique case ({fire, bus.rcredit})
            2'b10:   ocred_d = ocred_q - 1'b1;
            2'b01: begin
                if (ocred_q == OcredW'(RCRED_MAX)) cred_err = 1'b1;
                else                                 ocred_d  = ocred_q + 1'b1;
            end
            default: ocred_d = ocred_q;
        endcase

        icred_d = icred_q;
        if (icred_q != '0) icred_d = icred_d - 1'b1;
        if (pop)           icred_d = icred_d + 1'b1;
    end

    // Packer FSM with collate registers, credit counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StCollect;
            lane_q     <= '0;
            coll_q     <= '0;
            ckeep_q    <= '0;
            ocred_q    <= OcredW'(RCRED_MAX);
            icred_q    <= IcredW'(DEPTH);
            wcredit_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rkeep_q    <= '0;
            err_ovf_q  <= 1'b0;
            err_cred_q <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (pop) begin
                        if (complete && fire) begin
                            coll_q  <= '0;
                            ckeep_q <= '0;
                            lane_q  <= '0;
                        end else begin
                            coll_q  <= coll_d;
                            ckeep_q <= ckeep_d;
                            if (complete) state_q <= StHold;
                            else          lane_q  <= lane_q + LaneW'(1);
                        end
                    end
                end
                StHold: begin
                    if (fire) begin
                        coll_q  <= '0;
                        ckeep_q <= '0;
                        lane_q  <= '0;
                        state_q <= StCollect;
                    end
                end
                default: state_q <= StCollect;
            endcase

            rvalid_q <= fire;
            if (fire) begin
                rdata_q <= pdata;
                rkeep_q <= pkeep;
            end
            ocred_q    <= ocred_d;
            icred_q    <= icred_d;
            wcredit_q  <= (icred_q != '0);
            err_ovf_q  <= err_ovf_q | (bus.wvalid & fifo_full);
            err_cred_q <= err_cred_q | cred_err;
        end
    end

    assign bus.wcredit  = wcredit_q;
    assign bus.rdata    = rdata_q;
    assign bus.rkeep    = rkeep_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.err_ovf  = err_ovf_q;
    assign bus.err_cred = err_cred_q;
endmodule

// File: tb/tb_ah_packet_packer.sv
// Directed bench: dut0 uses LSB-first lanes, dut1 (same stimulus) uses MSB-first lanes.
module tb_ah_packet_packer;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   passed = 0;
    int   total  = 0;
    int   cnt;
    logic [31:0] last_rdata;

    ah_packet_packer_if #(.WIN(8), .RATIO(4)) if0 ();
    ah_packet_packer_if #(.WIN(8), .RATIO(4)) if1 ();

    assign if1.wdata   = if0.wdata;
    assign if1.wlast   = if0.wlast;
    assign if1.wvalid  = if0.wvalid;
    assign if1.rcredit = if0.rcredit;

    ah_packet_packer #(
        .WIN(8), .RATIO(4), .DEPTH(4), .RCRED_MAX(4), .LSB_FIRST(1'b1)
    ) dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0)
    );

    ah_packet_packer #(
        .WIN(8), .RATIO(4), .DEPTH(4), .RCRED_MAX(4), .LSB_FIRST(1'b0)
    ) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        if0.wdata  = d;
        if0.wlast  = last;
        if0.wvalid = 1'b1;
        tick();
        if0.wvalid = 1'b0;
        if0.wlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] p);
        for (int l = 0; l < 4; l++) send({p, 4'(l)}, 1'b0);
    endtask

    task automatic credit();
        if0.rcredit = 1'b1;
        tick();
        if0.rcredit = 1'b0;
    endtask

    initial begin
        if0.wdata   = '0;
        if0.wlast   = 1'b0;
        if0.wvalid  = 1'b0;
        if0.rcredit = 1'b0;
        repeat (3) tick();
        chk("rst_wcredit", 32'(if0.wcredit), 32'd0);
        chk("rst_rvalid",  32'(if0.rvalid), 32'd0);
        chk("rst_rdata",   if0.rdata, 32'h0);
        chk("rst_rkeep",   32'(if0.rkeep), 32'h0);
        chk("rst_err_ovf", 32'(if0.err_ovf), 32'd0);
        chk("rst_err_cred", 32'(if0.err_cred), 32'd0);

        // Four initial credit pulses back-to-back, then silence.
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("init_wcredit", 32'(if0.wcredit), 32'd1);
        end
        tick();
        chk("init_wcredit_end", 32'(if0.wcredit), 32'd0);
        chk("init_rvalid", 32'(if0.rvalid), 32'd0);

        // Full packet: rvalid one cycle after the fourth pop.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("full_early", 32'(if0.rvalid), 32'd0);
        tick();
        chk("full_rvalid", 32'(if0.rvalid), 32'd1);
        chk("full_rdata", if0.rdata, 32'h44332211);
        chk("full_rkeep", 32'(if0.rkeep), 32'hf);
        chk("full_msb_rdata", if1.rdata, 32'h11223344);
        chk("pop_wcredit", 32'(if0.wcredit), 32'd1);
        tick();
        chk("rvalid_pulse", 32'(if0.rvalid), 32'd0);
        chk("rdata_hold", if0.rdata, 32'h44332211);
        credit();

        // Partial packet with both lane orderings.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("part_early", 32'(if0.rvalid), 32'd0);
        tick();
        chk("part_rvalid", 32'(if0.rvalid), 32'd1);
        chk("part_rdata_lsb", if0.rdata, 32'h0000BBAA);
        chk("part_rkeep_lsb", 32'(if0.rkeep), 32'h3);
        chk("part_rdata_msb", if1.rdata, 32'hAABB0000);
        chk("part_rkeep_msb", 32'(if1.rkeep), 32'hc);
        credit();

        // Single-word packet: minimum latency of two cycles.
        send(8'h5A, 1'b1);
        chk("min_early", 32'(if0.rvalid), 32'd0);
        tick();
        chk("min_rvalid", 32'(if0.rvalid), 32'd1);
        chk("min_rdata", if0.rdata, 32'h0000005A);
        chk("min_rkeep", 32'(if0.rkeep), 32'h1);
        credit();

        // Credit at max is flagged and ignored.
        chk("cred_err_pre", 32'(if0.err_cred), 32'd0);
        credit();
        chk("cred_err_set", 32'(if0.err_cred), 32'd1);

        // Five packets with no credits returned: exactly four fire.
        cnt = 0;
        last_rdata = '0;
        for (int p = 1; p <= 5; p++) begin
            for (int l = 0; l < 4; l++) begin
                send({4'(p), 4'(l)}, 1'b0);
                if (if0.rvalid) begin
                    cnt++;
                    last_rdata = if0.rdata;
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if0.rvalid) begin
                cnt++;
                last_rdata = if0.rdata;
            end
        end
        chk("five_pkt_count", 32'(cnt), 32'd4);
        chk("five_pkt_last", last_rdata, 32'h43424140);

        // Leaving HOLD: credit in cycle c gives rvalid at c+2.
        credit();
        chk("hold_early", 32'(if0.rvalid), 32'd0);
        tick();
        chk("hold_rvalid", 32'(if0.rvalid), 32'd1);
        chk("hold_rdata", if0.rdata, 32'h53525150);

        // Fire and credit in the same cycle leave the count unchanged (stays 1).
        credit();
        send_pkt(4'h6);
        if0.rcredit = 1'b1;
        tick();
        if0.rcredit = 1'b0;
        chk("fc_rvalid", 32'(if0.rvalid), 32'd1);
        chk("fc_rdata", if0.rdata, 32'h63626160);
        send_pkt(4'h7);
        tick();
        chk("fc_next_fires", 32'(if0.rvalid), 32'd1);
        chk("fc_next_rdata", if0.rdata, 32'h73727170);
        send_pkt(4'h8);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if0.rvalid) cnt++;
        end
        chk("fc_then_hold", 32'(cnt), 32'd0);

        // Overflow while held: fifth word is dropped, flag is sticky.
        send_pkt(4'hD);
        chk("ovf_pre", 32'(if0.err_ovf), 32'd0);
        send(8'hEE, 1'b0);
        chk("ovf_set", 32'(if0.err_ovf), 32'd1);
        credit();
        tick();
        chk("ovf_held_rvalid", 32'(if0.rvalid), 32'd1);
        chk("ovf_held_rdata", if0.rdata, 32'h83828180);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if0.rvalid) cnt++;
        end
        chk("ovf_no_credit", 32'(cnt), 32'd0);
        credit();
        tick();
        chk("ovf_after_rvalid", 32'(if0.rvalid), 32'd1);
        chk("ovf_after_rdata", if0.rdata, 32'hD3D2D1D0);
        chk("ovf_after_rkeep", 32'(if0.rkeep), 32'hf);
        tick();
        chk("ovf_no_extra", 32'(if0.rvalid), 32'd0);
        credit();
        send(8'h21, 1'b1);
        tick();
        chk("post_rvalid", 32'(if0.rvalid), 32'd1);
        chk("post_rdata", if0.rdata, 32'h00000021);
        chk("post_rkeep", 32'(if0.rkeep), 32'h1);
        chk("ovf_sticky", 32'(if0.err_ovf), 32'd1);
        chk("cred_sticky", 32'(if0.err_cred), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
